// File: rtl/body_code_generator_pkg.sv
// Shared types and code constants for the 3-bit body-code transmitter.
// Type-1 codes are the two uniform words; type-0 codes are everything in between.
package body_code_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [2:0] CODE_T1_LO    = 3'b000;
  localparam logic [2:0] CODE_T1_HI    = 3'b111;
  localparam logic [2:0] CODE_T0_FIRST = 3'b001;
  localparam logic [2:0] CODE_T0_LAST  = 3'b110;

  // Type-0 walk wraps from 110 back to 001 so it never lands on a type-1 word.
  function automatic logic [2:0] next_t0(input logic [2:0] idx);
    return (idx == CODE_T0_LAST) ? CODE_T0_FIRST : idx + 3'd1;
  endfunction

endpackage

// File: rtl/body_code_generator_if.sv
// Request and code-stream handshake bundle for the body-code generator.
// The slave modport is the generator; the master modport is whoever feeds and drains it.
interface body_code_generator_if #(
  parameter int LEN_W = 4
);

  logic             req_valid;
  logic             req_type;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             code_valid;
  logic [2:0]       code;
  logic             code_ready;

  modport master (
    output req_valid, req_type, req_len, code_ready,
    input  req_ready, code_valid, code
  );

  modport slave (
    input  req_valid, req_type, req_len, code_ready,
    output req_ready, code_valid, code
  );

endinterface

// File: rtl/body_code_generator_sel.sv
// Pattern state for both body types: presents the current and post-advance code for
// the selected type, and steps that type's pattern on each transfer strobe.
module body_code_sel
  import body_code_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_type,
  input  logic       advance,
  output logic [2:0] code_now,
  output logic [2:0] code_next
);

  logic       ph1;
  logic [2:0] idx0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph1  <= 1'b0;
      idx0 <= CODE_T0_FIRST;
    end else if (advance) begin
      if (sel_type) begin
        ph1 <= ~ph1;
      end else begin
        idx0 <= next_t0(idx0);
      end
    end
  end

  // code_next lets the top load the following word in the same edge as the transfer.
  always_comb begin
    code_now  = idx0;
    code_next = next_t0(idx0);
    if (sel_type) begin
      code_now  = ph1 ? CODE_T1_HI : CODE_T1_LO;
      code_next = ph1 ? CODE_T1_LO : CODE_T1_HI;
    end
  end

endmodule

// File: rtl/body_code_generator.sv
// Transmit side of the 3-bit body-code link: accepts burst requests and streams
// req_len+1 legal codes of the requested type, keeping saturating per-type totals.
module body_code_generator
  import body_code_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  body_code_generator_if.slave bus,
  output logic [CNT_W-1:0]     count_t1,
  output logic [CNT_W-1:0]     count_t0,
  output logic                 busy
);

  state_t           state;
  state_t           state_next;
  logic             type_q;
  logic [LEN_W-1:0] remaining;
  logic             code_valid_q;
  logic [2:0]       code_q;

  logic             accept;
  logic             transfer;
  logic             sel_type;
  logic [2:0]       sel_now;
  logic [2:0]       sel_next;

  // While idle the selector looks at the incoming type so the first word is ready at accept.
  assign sel_type = (state == IDLE) ? bus.req_type : type_q;

  body_code_sel u_sel (
    .clk       (clk),
    .rst       (rst),
    .sel_type  (sel_type),
    .advance   (transfer),
    .code_now  (sel_now),
    .code_next (sel_next)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    transfer   = 1'b0;
    unique case (state)
      IDLE: begin
        accept = bus.req_valid;
        if (accept) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        transfer = code_valid_q & bus.code_ready;
        if (transfer && (remaining == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Code and valid only move on accept or transfer, which keeps them frozen under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      type_q       <= 1'b0;
      remaining    <= '0;
      code_valid_q <= 1'b0;
      code_q       <= CODE_T1_LO;
    end else begin
      state <= state_next;
      if (accept) begin
        type_q       <= bus.req_type;
        remaining    <= bus.req_len;
        code_q       <= sel_now;
        code_valid_q <= 1'b1;
      end else if (transfer) begin
        if (remaining == '0) begin
          code_valid_q <= 1'b0;
        end else begin
          remaining <= remaining - 1'b1;
          code_q    <= sel_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_t1 <= '0;
      count_t0 <= '0;
    end else if (transfer) begin
      if (type_q && (count_t1 != '1)) begin
        count_t1 <= count_t1 + 1'b1;
      end
      if (!type_q && (count_t0 != '1)) begin
        count_t0 <= count_t0 + 1'b1;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.code_valid = code_valid_q;
  assign bus.code       = code_q;
  assign busy           = (state == EMIT);

endmodule

// File: tb/tb_body_code_generator.sv
// Self-checking bench for body_code_generator: a burst-level model predicts every
// emitted code and the counter totals, with literal sequences pinning the model.
module tb_body_code_generator;

  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  body_code_generator_if #(.LEN_W(LEN_W)) bus ();
  body_code_generator_if #(.LEN_W(LEN_W)) bus_s ();

  logic [15:0] count_t1;
  logic [15:0] count_t0;
  logic        busy;
  logic [2:0]  count_t1_s;
  logic [2:0]  count_t0_s;
  logic        busy_s;

  body_code_generator #(.LEN_W(LEN_W), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .count_t1 (count_t1),
    .count_t0 (count_t0),
    .busy     (busy)
  );

  body_code_generator #(.LEN_W(LEN_W), .CNT_W(3)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_s.slave),
    .count_t1 (count_t1_s),
    .count_t0 (count_t0_s),
    .busy     (busy_s)
  );

  int checks   = 0;
  int failures = 0;
  bit compare_en = 1'b0;

  // Burst-level model: codes of an accepted burst are queued up front.
  bit          m_active = 1'b0;
  bit          m_was_active;
  bit          m_type = 1'b0;
  logic [2:0]  m_q[$];
  bit          m_ph1 = 1'b0;
  logic [2:0]  m_idx0 = 3'd1;
  int          m_c1 = 0;
  int          m_c0 = 0;
  int          s_xfers = 0;
  logic [2:0]  xfer_log[$];

  function automatic bit classify(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b111);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out at %0t", name, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_q.delete();
      m_ph1    = 1'b0;
      m_idx0   = 3'd1;
      m_c1     = 0;
      m_c0     = 0;
      s_xfers  = 0;
    end else begin
      m_was_active = m_active;
      if (m_active && bus.code_ready) begin
        if (bus.code_valid) xfer_log.push_back(bus.code);
        if (m_q.size() > 0) void'(m_q.pop_front());
        if (m_type) m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
        else        m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
        if (m_q.size() == 0) m_active = 1'b0;
      end
      if (!m_was_active && bus.req_valid) begin
        m_type = bus.req_type;
        for (int i = 0; i <= int'(bus.req_len); i++) begin
          if (m_type) begin
            m_q.push_back(m_ph1 ? 3'b111 : 3'b000);
            m_ph1 = ~m_ph1;
          end else begin
            m_q.push_back(m_idx0);
            m_idx0 = (m_idx0 == 3'd6) ? 3'd1 : m_idx0 + 3'd1;
          end
        end
        m_active = 1'b1;
      end
      if (bus_s.code_valid && bus_s.code_ready) s_xfers++;
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("code_valid", 32'(bus.code_valid), 32'(m_active));
      checkOutput("req_ready", 32'(bus.req_ready), 32'(!m_active));
      checkOutput("busy", 32'(busy), 32'(m_active));
      if (m_active && (m_q.size() > 0)) begin
        checkOutput("code", 32'(bus.code), 32'(m_q[0]));
        checkOutput("classify", 32'(classify(bus.code)), 32'(m_type));
      end
      checkOutput("count_t1", 32'(count_t1), 32'(m_c1));
      checkOutput("count_t0", 32'(count_t0), 32'(m_c0));
      checkOutput("sat_count_t1", 32'(count_t1_s), 32'((s_xfers > 7) ? 7 : s_xfers));
      checkOutput("sat_count_t0", 32'(count_t0_s), 32'(0));
    end
  end

  task automatic applyStimulus(input bit t, input int len);
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) timeoutFail("req_ready_wait");
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_len   = LEN_W'(len);
    @(negedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (m_active && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (m_active) timeoutFail(name);
  endtask

  task automatic checkLog(input string tag, input logic [2:0] expq[$]);
    checkOutput({tag, "_len"}, 32'(xfer_log.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < xfer_log.size())
        checkOutput($sformatf("%s_code%0d", tag, i), 32'(xfer_log[i]), 32'(expq[i]));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] expq[$];
    bit         pat[4];
    int         n;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_type     = 1'b0;
    bus.req_len      = '0;
    bus.code_ready   = 1'b0;
    bus_s.req_valid  = 1'b0;
    bus_s.req_type   = 1'b0;
    bus_s.req_len    = '0;
    bus_s.code_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_code_valid", 32'(bus.code_valid), 32'(0));
    checkOutput("rst_code", 32'(bus.code), 32'(0));
    checkOutput("rst_count_t1", 32'(count_t1), 32'(0));
    checkOutput("rst_count_t0", 32'(count_t0), 32'(0));
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'(1));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    #1;
    rst = 1'b0;
    compare_en = 1'b1;

    $display("[TB] test 1: type1 burst of 4");
    bus.code_ready = 1'b1;
    xfer_log.delete();
    applyStimulus(1'b1, 3);
    waitIdle("t1_idle");
    expq = '{3'b000, 3'b111, 3'b000, 3'b111};
    checkLog("t1", expq);
    checkOutput("t1_count_t1", 32'(count_t1), 32'(4));
    checkOutput("t1_gap_req_ready", 32'(bus.req_ready), 32'(1));

    $display("[TB] test 2: type0 burst of 8 then 1");
    xfer_log.delete();
    applyStimulus(1'b0, 7);
    waitIdle("t2_idle");
    applyStimulus(1'b0, 0);
    waitIdle("t2b_idle");
    expq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b010, 3'b011};
    checkLog("t2", expq);
    checkOutput("t2_count_t0", 32'(count_t0), 32'(9));

    $display("[TB] test 3: type1 burst with stalls");
    xfer_log.delete();
    applyStimulus(1'b1, 3);
    n = 0;
    while (m_active && n < 100) begin
      bus.code_ready = pat[n % 4];
      @(negedge clk);
      #1;
      n++;
    end
    if (m_active) timeoutFail("t3_idle");
    bus.code_ready = 1'b1;
    expq = '{3'b000, 3'b111, 3'b000, 3'b111};
    checkLog("t3", expq);
    checkOutput("t3_count_t1", 32'(count_t1), 32'(8));

    $display("[TB] test 4: request held during burst");
    xfer_log.delete();
    applyStimulus(1'b0, 3);
    bus.req_valid = 1'b1;
    bus.req_type  = 1'b1;
    bus.req_len   = LEN_W'(1);
    waitIdle("t4_idle");
    checkOutput("t4_gap_req_ready", 32'(bus.req_ready), 32'(1));
    checkOutput("t4_gap_code_valid", 32'(bus.code_valid), 32'(0));
    @(negedge clk);
    #1;
    bus.req_valid = 1'b0;
    waitIdle("t4b_idle");
    expq = '{3'b100, 3'b101, 3'b110, 3'b001, 3'b000, 3'b111};
    checkLog("t4", expq);
    checkOutput("t4_count_t1", 32'(count_t1), 32'(10));
    checkOutput("t4_count_t0", 32'(count_t0), 32'(13));

    $display("[TB] test 5: reset mid type0 burst");
    xfer_log.delete();
    applyStimulus(1'b0, 5);
    n = 0;
    while (xfer_log.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (xfer_log.size() < 2) timeoutFail("t5_two_codes");
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_code_valid", 32'(bus.code_valid), 32'(0));
    checkOutput("t5_count_t0", 32'(count_t0), 32'(0));
    checkOutput("t5_count_t1", 32'(count_t1), 32'(0));
    #1;
    rst = 1'b0;
    expq = '{3'b010, 3'b011};
    checkLog("t5_pre", expq);
    xfer_log.delete();
    applyStimulus(1'b0, 1);
    waitIdle("t5_idle");
    expq = '{3'b001, 3'b010};
    checkLog("t5_post", expq);
    checkOutput("t5_post_count_t0", 32'(count_t0), 32'(2));

    $display("[TB] test 6: counter saturation with CNT_W=3");
    bus_s.code_ready = 1'b1;
    bus_s.req_valid  = 1'b1;
    bus_s.req_type   = 1'b1;
    bus_s.req_len    = LEN_W'(9);
    @(negedge clk);
    #1;
    bus_s.req_valid = 1'b0;
    n = 0;
    while (s_xfers < 10 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (s_xfers < 10) timeoutFail("t6_transfers");
    @(negedge clk);
    checkOutput("t6_sat_count_t1", 32'(count_t1_s), 32'(7));
    checkOutput("t6_sat_count_t0", 32'(count_t0_s), 32'(0));
    checkOutput("t6_sat_busy", 32'(busy_s), 32'(0));

    compare_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
